// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes and FSM states.
package muldiv_seq_pkg;

  localparam logic [1:0] MDOP_MULTU = 2'b00;
  localparam logic [1:0] MDOP_MULT  = 2'b01;
  localparam logic [1:0] MDOP_DIVU  = 2'b10;
  localparam logic [1:0] MDOP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_CALC = 2'b10,
    ST_FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier / restoring divider.
// Multiply: acc = {partial_product_hi, multiplier_bits}, consumed LSB first.
// Divide:   acc = {remainder, dividend_bits/quotient}, consumed MSB first.
// The single 33-bit adder is shared: it adds for multiply and subtracts for divide.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   mag,
  input  logic           is_div,
  output logic [2*W-1:0] acc_next
);

  logic [W:0]   opa;
  logic [W:0]   opb;
  logic         cin;
  logic [W+1:0] sum;

  // Select adder operands: add multiplicand when multiplier bit is set, or trial-subtract divisor.
  always_comb begin
    opa = '0;
    opb = '0;
    cin = 1'b0;
    if (is_div) begin
      // Shifted remainder can need 33 bits, so take it straight from acc[2W-1:W-1].
      opa = acc[2*W-1:W-1];
      opb = ~{1'b0, mag};
      cin = 1'b1;
    end else begin
      opa = {1'b0, acc[2*W-1:W]};
      opb = acc[0] ? {1'b0, mag} : '0;
      cin = 1'b0;
    end
  end

  assign sum = {1'b0, opa} + {1'b0, opb} + {{(W+1){1'b0}}, cin};

  // Form the next accumulator; for divide the carry-out means the difference is non-negative.
  always_comb begin
    acc_next = '0;
    if (is_div) begin
      if (sum[W+1]) begin
        acc_next = {sum[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*W-2:0], 1'b0};
      end
    end else begin
      // Carry is kept as the new MSB before the right shift.
      acc_next = {sum[W:0], acc[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Handshake: start is accepted only when busy=0; busy stays high from the cycle after
// acceptance through the sign-fix cycle; done pulses for one cycle as HI/LO update.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       state_dbg
);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   mag_q;
  logic               res_neg;
  logic               dvd_neg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [5:0]         cnt;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  muldiv_step #(.W(WIDTH)) u_step (
    .acc      (acc),
    .mag      (mag_q),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> PREP -> CALC x32 -> FIX -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PREP;
      ST_PREP: state_nxt = ST_CALC;
      ST_CALC: if (cnt == 6'd1) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand magnitudes and final sign correction.
  always_comb begin
    mag_a    = (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    mag_b    = (is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    prod_fix = res_neg ? (~acc + 1'b1) : acc;
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        // Divide by zero: dividend passes through unchanged, quotient saturates to all ones.
        hi_res = a_q;
        lo_res = '1;
      end else begin
        lo_res = res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        hi_res = dvd_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Operand capture, preparation and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= MDOP_MULTU;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      res_neg <= 1'b0;
      dvd_neg <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= A;
            b_q  <= B;
          end
        end
        ST_PREP: begin
          // Multiply iterates over B with |A| as addend; divide iterates over |A| with |B| as divisor.
          mag_q   <= is_div ? mag_b : mag_a;
          acc     <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          res_neg <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          dvd_neg <= is_signed & a_q[WIDTH-1];
          cnt     <= 6'(WIDTH);
        end
        ST_CALC: begin
          acc <= acc_next;
          cnt <= cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO: results land in FIX; MTHI/MTLO writes only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      HI <= '0;
      LO <= '0;
    end else if (state == ST_FIX) begin
      HI <= hi_res;
      LO <= lo_res;
    end else if (!busy) begin
      if (hi_we) HI <= wdata;
      if (lo_we) LO <= wdata;
    end
  end

  // One-cycle completion pulse following the FIX cycle.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (state == ST_FIX);
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a result scoreboard fed at launch time.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [1:0]  state_dbg;

  logic [63:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .HI        (HI),
    .LO        (LO),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse pops one expected {HI,LO}.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", 64'(HI), 64'(e[63:32]));
        check("result_lo", 64'(LO), 64'(e[31:0]));
      end
    end
  end

  // Drive start for one edge starting from the current time.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count busy cycles sampled on negedges; returns at the first idle negedge.
  task automatic wait_idle(output int n);
    n = 0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    exp_q.push_back({eh, el});
    launch(o, a, b);
    wait_idle(n);
    check({name, "_busy_cycles"}, 64'(n), 64'd34);
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    pass_cnt  = 0;
    total_cnt = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = MDOP_MULTU;
    A     = '0;
    B     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));

    // MTHI then MTLO while idle.
    hi_we = 1'b1; wdata = 32'hA5A5_0001;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_0002;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mthi", 64'(HI), 64'hA5A5_0001);
    check("mtlo", 64'(LO), 64'h5A5A_0002);
    @(negedge clk);

    // MULTU max*max with a same-cycle MTLO: write lands now, result overwrites later.
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    lo_we = 1'b1; wdata = 32'h0000_1234;
    launch(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lo_we = 1'b0;
    check("same_cycle_mtlo", 64'(LO), 64'h0000_1234);
    check("busy_cycle1", 64'(busy), 64'd1);
    wait_idle(n);
    check("multu_busy_cycles", 64'(n), 64'd34);
    check("multu_done", 64'(done), 64'd1);

    // Back-to-back launches, each issued in the done cycle of the previous one.
    run_op("mult_neg",   MDOP_MULT, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",    MDOP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",    MDOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero",  MDOP_DIVU, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op("div_zero",   MDOP_DIV,  32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF);
    run_op("divu_big",   MDOP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF);
    run_op("div_negdiv", MDOP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

    // MULTU 6x7 with start and MTLO asserted mid-operation: both must be dropped.
    exp_q.push_back({32'd0, 32'd42});
    launch(MDOP_MULTU, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    op = MDOP_DIVU; A = 32'd5; B = 32'd1; start = 1'b1;
    lo_we = 1'b1; wdata = 32'h0000_DEAD;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    check("busy_mtlo_dropped", 64'(LO), 64'hFFFF_FFFD);
    wait_idle(n);
    check("ignored_start_busy_rest", 64'(n), 64'd24);
    check("ignored_start_done", 64'(done), 64'd1);

    // Rerun and reset in cycle 20: abort with no result and no done.
    launch(MDOP_MULTU, 32'd6, 32'd7);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
    repeat (40) @(negedge clk);
    check("abort_still_idle", 64'(busy), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
